obi_rr_arbiter: RTL and testbench
=================================

// Module: obi_rr_arbiter
// PURPOSE
// Shares one OBI subordinate port between NumMgr OBI manager ports using round-robin arbitration.
// Routes each response back to the manager that issued the request, in order, via an index FIFO.
// Sits between core/DMA managers and a single memory or peripheral subordinate in the interconnect.
// Request path is combinational: zero added latency. Response path is combinational from the FIFO head.
// PARAMETERS
// NumMgr    2   number of manager ports, >= 2
// AddrWidth 32  address width
// DataWidth 32  data width; byte-enable width is DataWidth/8
// IdWidth   1   aid/rid width, passed through unchanged
// MaxTrans  4   max outstanding transactions, i.e. index FIFO depth, >= 1
// UseRReady 0   1: honour rready handshake; 0: rready treated as constant 1
// PORTS
// clk_i        in   1               clock
// rst_ni       in   1               asynchronous reset, active-low
// mgr_req_i    in   NumMgr          per-manager request
// mgr_gnt_o    out  NumMgr          per-manager grant
// mgr_addr_i   in   NumMgr*AW       packed addresses, manager i at [i*AW +: AW]
// mgr_we_i     in   NumMgr          write enable
// mgr_be_i     in   NumMgr*DW/8     byte enables
// mgr_wdata_i  in   NumMgr*DW       write data
// mgr_aid_i    in   NumMgr*IW       request id
// mgr_rvalid_o out  NumMgr          per-manager response valid
// mgr_rready_i in   NumMgr          per-manager response ready
// mgr_rdata_o  out  DW              response data, broadcast to all managers
// mgr_rid_o    out  IW              response id, broadcast
// mgr_err_o    out  1               response error, broadcast
// sbr_req_o    out  1               request to subordinate
// sbr_gnt_i    in   1               grant from subordinate
// sbr_addr_o / sbr_we_o / sbr_be_o / sbr_wdata_o / sbr_aid_o  out  AW/1/DW/8/DW/IW  selected A channel
// sbr_rvalid_i in   1               response valid from subordinate
// sbr_rready_o out  1               response ready to subordinate
// sbr_rdata_i / sbr_rid_i / sbr_err_i  in  DW/IW/1  R channel from subordinate
// BEHAVIOUR
// - Reset: sbr_req_o=0, mgr_gnt_o=0, mgr_rvalid_o=0, rr pointer=0, FIFO empty, lock cleared.
// - Arbitration: among asserted mgr_req_i, pick the first index at or after the rr pointer, modulo NumMgr.
// - Request forwarding: sbr_req_o = selected request && !fifo_full. Selected A fields drive sbr_*.
// - Grant: mgr_gnt_o[sel] = sbr_gnt_i && sbr_req_o. All other grants are 0.
// - Handshake on sbr_req_o && sbr_gnt_i:
//   - push sel into the FIFO;
//   - rr pointer <= (sel+1) mod NumMgr;
//   - clear the lock.
// - Lock: if sbr_req_o && !sbr_gnt_i, register sel and hold it until the grant.
//   - Keeps the A channel stable, as OBI requires.
//   - Higher-priority requests arriving meanwhile do not preempt.
// - FIFO full (MaxTrans outstanding): sbr_req_o=0 and no grant, even if a pop occurs in the same cycle.
// - Response routing: mgr_rvalid_o[head] = sbr_rvalid_i && !fifo_empty; sbr_rready_o = mgr_rready_i[head].
//   - When UseRReady=0, sbr_rready_o is constant 1.
//   - Pop the FIFO on sbr_rvalid_i && sbr_rready_o.
// - Simultaneous push and pop (not full): both occur; occupancy is unchanged.
// - sbr_rvalid_i while the FIFO is empty: protocol violation. Dropped (no mgr_rvalid_o) and flagged by an assertion.
// - Reset mid-operation: the FIFO and lock clear immediately (asynchronous). Outstanding responses are lost.
// - Width rules:
//   - FIFO entry width = $clog2(NumMgr).
//   - Occupancy counter width = $clog2(MaxTrans+1).
//   - Pointers wrap modulo MaxTrans.
// TESTING
// - Reset: rst_ni=0 with random inputs -> all gnt/rvalid/sbr_req_o=0. After release, FIFO empty and rr pointer=0.
// - Round-robin: NumMgr=4, all req=1, sbr_gnt_i=1 every cycle -> grants 0,1,2,3,0 in consecutive cycles.
// - Lock: mgr0 req, sbr_gnt_i=0 for 3 cycles, mgr1 raises req in cycle 1 -> sbr_addr_o stays mgr0's; mgr1 granted after mgr0.
// - FIFO full: MaxTrans=2, two grants, no rvalid -> third request sees sbr_req_o=0. It is granted the cycle after the first rvalid pop.
// - Routing: grant mgr2 then mgr0, rvalid twice -> mgr_rvalid_o=4'b0100, then 4'b0001; rdata matches subordinate each time.
// - Backpressure: UseRReady=1, mgr_rready_i[head]=0 for 2 cycles -> sbr_rready_o=0 and no pop; pop in the cycle rready rises.

Source files
------------

// File: rtl/obi_rr_arbiter.sv
// Round-robin OBI arbiter: NumMgr managers share one subordinate. Request path is combinational, with no added latency.
// The response path is combinational from the index FIFO head. A stalled request is locked until the subordinate grants it.

module sync_fifo #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [Width-1:0] push_dat,
  input  logic             pop,
  output logic [Width-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic [CntW-1:0]  cnt;
  logic             do_push, do_pop;

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (cnt == CntW'(Depth));
  assign empty    = (cnt == '0);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module obi_rr_arbiter #(
  parameter int unsigned NumMgr    = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 1,
  parameter int unsigned MaxTrans  = 4,
  parameter bit          UseRReady = 1'b0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumMgr-1:0]              mgr_req_i,
  output logic [NumMgr-1:0]              mgr_gnt_o,
  input  logic [NumMgr*AddrWidth-1:0]    mgr_addr_i,
  input  logic [NumMgr-1:0]              mgr_we_i,
  input  logic [NumMgr*DataWidth/8-1:0]  mgr_be_i,
  input  logic [NumMgr*DataWidth-1:0]    mgr_wdata_i,
  input  logic [NumMgr*IdWidth-1:0]      mgr_aid_i,
  output logic [NumMgr-1:0]              mgr_rvalid_o,
  input  logic [NumMgr-1:0]              mgr_rready_i,
  output logic [DataWidth-1:0]           mgr_rdata_o,
  output logic [IdWidth-1:0]             mgr_rid_o,
  output logic                           mgr_err_o,
  output logic                           sbr_req_o,
  input  logic                           sbr_gnt_i,
  output logic [AddrWidth-1:0]           sbr_addr_o,
  output logic                           sbr_we_o,
  output logic [DataWidth/8-1:0]         sbr_be_o,
  output logic [DataWidth-1:0]           sbr_wdata_o,
  output logic [IdWidth-1:0]             sbr_aid_o,
  input  logic                           sbr_rvalid_i,
  output logic                           sbr_rready_o,
  input  logic [DataWidth-1:0]           sbr_rdata_i,
  input  logic [IdWidth-1:0]             sbr_rid_i,
  input  logic                           sbr_err_i
);
  localparam int unsigned SelW = $clog2(NumMgr);
  localparam int unsigned BeW  = DataWidth / 8;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 we;
    logic [BeW-1:0]       be;
    logic [DataWidth-1:0] wdata;
    logic [IdWidth-1:0]   aid;
  } hdr_t;

  hdr_t            mgr_hdr [NumMgr];
  hdr_t            sel_hdr;
  logic [SelW-1:0] rr_ptr, arb_sel, sel, lock_sel, head;
  logic            arb_vld, sel_req, lock_vld, hs, pop;
  logic            fifo_full, fifo_empty;

  always_comb begin
    for (int i = 0; i < int'(NumMgr); i++) begin
      mgr_hdr[i] = '{addr:  mgr_addr_i[i*AddrWidth +: AddrWidth],
                     we:    mgr_we_i[i],
                     be:    mgr_be_i[i*BeW +: BeW],
                     wdata: mgr_wdata_i[i*DataWidth +: DataWidth],
                     aid:   mgr_aid_i[i*IdWidth +: IdWidth]};
    end
  end

  // Scan from farthest to nearest offset so the first requester at/after rr_ptr wins.
  always_comb begin
    int idx;
    idx     = 0;
    arb_vld = 1'b0;
    arb_sel = '0;
    for (int k = int'(NumMgr) - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % int'(NumMgr);
      if (mgr_req_i[idx]) begin
        arb_vld = 1'b1;
        arb_sel = SelW'(idx);
      end
    end
  end

  assign sel       = lock_vld ? lock_sel : arb_sel;
  assign sel_req   = lock_vld ? mgr_req_i[lock_sel] : arb_vld;
  assign sel_hdr   = mgr_hdr[sel];
  assign sbr_req_o = rst_ni && sel_req && !fifo_full;
  assign hs        = sbr_req_o && sbr_gnt_i;
  assign mgr_gnt_o = hs ? (NumMgr'(1) << sel) : '0;

  assign sbr_addr_o  = sel_hdr.addr;
  assign sbr_we_o    = sel_hdr.we;
  assign sbr_be_o    = sel_hdr.be;
  assign sbr_wdata_o = sel_hdr.wdata;
  assign sbr_aid_o   = sel_hdr.aid;

  // A stalled request keeps its manager selected so the A channel stays stable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr   <= '0;
      lock_vld <= 1'b0;
      lock_sel <= '0;
    end else begin
      lock_vld <= sbr_req_o && !sbr_gnt_i;
      if (sbr_req_o) lock_sel <= sel;
      if (hs) rr_ptr <= (sel == SelW'(NumMgr - 1)) ? '0 : sel + 1'b1;
    end
  end

  sync_fifo #(
    .Width (SelW),
    .Depth (MaxTrans)
  ) idx_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push     (hs),
    .push_dat (sel),
    .pop      (pop),
    .head_dat (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign sbr_rready_o = mgr_rready_i[head] || !UseRReady;
  assign pop          = sbr_rvalid_i && sbr_rready_o && !fifo_empty;
  assign mgr_rvalid_o = (sbr_rvalid_i && !fifo_empty) ? (NumMgr'(1) << head) : '0;
  assign mgr_rdata_o  = sbr_rdata_i;
  assign mgr_rid_o    = sbr_rid_i;
  assign mgr_err_o    = sbr_err_i;

  rvalid_needs_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(sbr_rvalid_i && fifo_empty));
endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Bench for obi_rr_arbiter: 4 managers, MaxTrans=2, UseRReady=1; vector table, corner sequences, random vs queue model.
module tb_obi_rr_arbiter;
  localparam int NM = 4, AW = 32, DW = 32, IW = 2, MT = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NM-1:0]    req, gnt, rvalid, rready;
  logic [NM*AW-1:0] addr;
  logic [NM-1:0]    we;
  logic [NM*DW/8-1:0] be;
  logic [NM*DW-1:0] wdata;
  logic [NM*IW-1:0] aid;
  logic [DW-1:0]    rdata, s_rdata, s_wdata;
  logic [IW-1:0]    rid, s_rid, s_aid;
  logic             err, s_err, s_req, s_gnt, s_we, s_rvalid, s_rready;
  logic [AW-1:0]    s_addr;
  logic [DW/8-1:0]  s_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  obi_rr_arbiter #(
    .NumMgr(NM), .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .MaxTrans(MT), .UseRReady(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mgr_req_i(req), .mgr_gnt_o(gnt), .mgr_addr_i(addr), .mgr_we_i(we), .mgr_be_i(be),
    .mgr_wdata_i(wdata), .mgr_aid_i(aid), .mgr_rvalid_o(rvalid), .mgr_rready_i(rready),
    .mgr_rdata_o(rdata), .mgr_rid_o(rid), .mgr_err_o(err),
    .sbr_req_o(s_req), .sbr_gnt_i(s_gnt), .sbr_addr_o(s_addr), .sbr_we_o(s_we), .sbr_be_o(s_be),
    .sbr_wdata_o(s_wdata), .sbr_aid_o(s_aid), .sbr_rvalid_i(s_rvalid), .sbr_rready_o(s_rready),
    .sbr_rdata_i(s_rdata), .sbr_rid_i(s_rid), .sbr_err_i(s_err)
  );

  typedef struct {
    logic [3:0] req;
    logic       g;
    logic       rv;
    logic [3:0] rdy;
    logic       e_sreq;
    logic [3:0] e_gnt;
    logic [3:0] e_rv;
    logic       e_rrdy;
    int         e_sel;
  } vec_t;

  function automatic vec_t mk(logic [3:0] r, logic g, logic v, logic [3:0] d,
                              logic es, logic [3:0] eg, logic [3:0] ev, logic er, int sel);
    vec_t x;
    x.req = r; x.g = g; x.rv = v; x.rdy = d;
    x.e_sreq = es; x.e_gnt = eg; x.e_rv = ev; x.e_rrdy = er; x.e_sel = sel;
    return x;
  endfunction

  function automatic logic [31:0] mgr_addr(int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] r, input logic g, input logic v, input logic [3:0] d);
    req = r; s_gnt = g; s_rvalid = v; rready = d;
    s_rdata = $urandom; s_rid = IW'($urandom); s_err = 1'(($urandom));
    wdata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic apply(input vec_t v, input string name);
    set_in(v.req, v.g, v.rv, v.rdy);
    #2;
    chk({name, "_sreq"}, 32'(s_req), 32'(v.e_sreq));
    chk({name, "_gnt"}, 32'(gnt), 32'(v.e_gnt));
    chk({name, "_rvalid"}, 32'(rvalid), 32'(v.e_rv));
    chk({name, "_rready"}, 32'(s_rready), 32'(v.e_rrdy));
    chk({name, "_rdata"}, rdata, s_rdata);
    if (v.e_sel >= 0) chk({name, "_addr"}, s_addr, mgr_addr(v.e_sel));
    @(posedge clk); #1;
  endtask

  task automatic reset_cycles(input int n, input string name);
    rst_n = 1'b0;
    for (int c = 0; c < n; c++) begin
      set_in(4'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
      #2;
      chk({name, "_sreq"}, 32'(s_req), 32'd0);
      chk({name, "_gnt"}, 32'(gnt), 32'd0);
      chk({name, "_rvalid"}, 32'(rvalid), 32'd0);
      @(posedge clk); #1;
    end
    set_in(4'h0, 1'b0, 1'b0, 4'hF);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t tbl [15];
    int   q [$];
    int   rr, lock, sel;
    logic [3:0] pend, rdy, egnt, erv;
    logic g, rv, esreq;

    for (int i = 0; i < NM; i++) addr[i*AW +: AW] = mgr_addr(i);
    we = 4'b1010; be = '1; aid = 8'hE4;
    set_in(4'h0, 1'b0, 1'b0, 4'hF);

    // Round-robin with back-to-back grants and pops, then full FIFO, routing and rready backpressure.
    tbl[0]  = mk(4'hF, 1, 0, 4'hF, 1, 4'b0001, 4'b0000, 1, 0);
    tbl[1]  = mk(4'hF, 1, 1, 4'hF, 1, 4'b0010, 4'b0001, 1, 1);
    tbl[2]  = mk(4'hF, 1, 1, 4'hF, 1, 4'b0100, 4'b0010, 1, 2);
    tbl[3]  = mk(4'hF, 1, 1, 4'hF, 1, 4'b1000, 4'b0100, 1, 3);
    tbl[4]  = mk(4'hF, 1, 1, 4'hF, 1, 4'b0001, 4'b1000, 1, 0);
    tbl[5]  = mk(4'h0, 0, 1, 4'hF, 0, 4'b0000, 4'b0001, 1, -1);
    tbl[6]  = mk(4'h4, 1, 0, 4'hF, 1, 4'b0100, 4'b0000, 1, 2);
    tbl[7]  = mk(4'h1, 1, 0, 4'hF, 1, 4'b0001, 4'b0000, 1, 0);
    tbl[8]  = mk(4'h2, 1, 0, 4'hF, 0, 4'b0000, 4'b0000, 1, -1);
    tbl[9]  = mk(4'h2, 1, 1, 4'hF, 0, 4'b0000, 4'b0100, 1, -1);
    tbl[10] = mk(4'h2, 1, 1, 4'hF, 1, 4'b0010, 4'b0001, 1, 1);
    tbl[11] = mk(4'h0, 0, 1, 4'hD, 0, 4'b0000, 4'b0010, 0, -1);
    tbl[12] = mk(4'h0, 0, 1, 4'hD, 0, 4'b0000, 4'b0010, 0, -1);
    tbl[13] = mk(4'h0, 0, 1, 4'hF, 0, 4'b0000, 4'b0010, 1, -1);
    tbl[14] = mk(4'h0, 0, 0, 4'hF, 0, 4'b0000, 4'b0000, 1, -1);

    #1;
    reset_cycles(3, "rst");
    @(posedge clk); #1;
    for (int i = 0; i < 15; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Lock: move rr to 1 so mgr1 would win a fresh arbitration while mgr0 is stalled.
    apply(mk(4'h1, 1, 0, 4'hF, 1, 4'b0001, 4'b0000, 1, 0), "lk_pre");
    apply(mk(4'h0, 0, 1, 4'hF, 0, 4'b0000, 4'b0001, 1, -1), "lk_pop");
    apply(mk(4'h1, 0, 0, 4'hF, 1, 4'b0000, 4'b0000, 1, 0), "lk0");
    apply(mk(4'h3, 0, 0, 4'hF, 1, 4'b0000, 4'b0000, 1, 0), "lk1");
    apply(mk(4'h3, 0, 0, 4'hF, 1, 4'b0000, 4'b0000, 1, 0), "lk2");
    apply(mk(4'h3, 1, 0, 4'hF, 1, 4'b0001, 4'b0000, 1, 0), "lk3");
    apply(mk(4'h2, 1, 0, 4'hF, 1, 4'b0010, 4'b0000, 1, 1), "lk4");

    // Reset with two responses outstanding: they are lost, rr returns to 0, FIFO empty again.
    reset_cycles(2, "rst_mid");
    @(posedge clk); #1;
    apply(mk(4'hF, 1, 0, 4'hF, 1, 4'b0001, 4'b0000, 1, 0), "post0");
    apply(mk(4'hF, 1, 0, 4'hF, 1, 4'b0010, 4'b0000, 1, 1), "post1");
    apply(mk(4'hF, 1, 0, 4'hF, 0, 4'b0000, 4'b0000, 1, -1), "post_full");
    apply(mk(4'h0, 0, 1, 4'hF, 0, 4'b0000, 4'b0001, 1, -1), "drain0");
    apply(mk(4'h0, 0, 1, 4'hF, 0, 4'b0000, 4'b0010, 1, -1), "drain1");

    // Random traffic against an in-order queue model of outstanding requests.
    reset_cycles(1, "rst_rand");
    @(posedge clk); #1;
    rr = 0; lock = -1; pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NM; i++) if (!pend[i] && $urandom_range(0, 2) == 0) pend[i] = 1'b1;
      g   = ($urandom_range(0, 3) != 0);
      rv  = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      rdy = 4'($urandom);
      set_in(pend, g, rv, rdy);

      sel = lock;
      if (sel < 0)
        for (int k = 0; k < NM; k++)
          if (sel < 0 && pend[(rr + k) % NM]) sel = (rr + k) % NM;
      esreq = (sel >= 0) && (q.size() < MT);
      egnt  = (esreq && g) ? (4'd1 << sel) : 4'd0;
      erv   = (rv && q.size() > 0) ? (4'd1 << q[0]) : 4'd0;

      #2;
      chk("rnd_sreq", 32'(s_req), 32'(esreq));
      chk("rnd_gnt", 32'(gnt), 32'(egnt));
      chk("rnd_rvalid", 32'(rvalid), 32'(erv));
      if (q.size() > 0) chk("rnd_rready", 32'(s_rready), 32'(rdy[q[0]]));
      if (esreq) chk("rnd_addr", s_addr, mgr_addr(sel));
      @(posedge clk); #1;

      if (rv && q.size() > 0 && rdy[q[0]]) void'(q.pop_front());
      if (esreq && g) begin
        q.push_back(sel);
        rr = (sel + 1) % NM;
        lock = -1;
        pend[sel] = 1'b0;
      end else if (esreq) begin
        lock = sel;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
